// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_pkg
// Description : Shared types and B3/S23 rule constants for the Life grid.
// Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    // Grid controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // B3/S23: born with exactly 3 neighbours, survive with 2 or 3
    localparam logic [3:0] c_birth_count = 4'd3;
    localparam logic [3:0] c_survive_min = 4'd2;
    localparam logic [3:0] c_survive_max = 4'd3;

    // Next alive state of one cell given its current state and neighbour count
    function automatic logic life_rule(input logic alive, input logic [3:0] count);
        if (alive) begin
            return (count >= c_survive_min) && (count <= c_survive_max);
        end
        return (count == c_birth_count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_cell.sv
`default_nettype none
// ============================================================================
// Module      : life_cell
// Description : One Life cell: neighbour count, B3/S23 rule, state register.
// Revision    : 1.0 - initial release
// ============================================================================
module life_cell
    import life_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       seed,
    input  logic       enable,
    input  logic [7:0] neighbors,
    output logic       next_alive,
    output logic       alive
);

    logic [3:0] w_count;
    logic       r_alive;

    // Sum of the eight neighbour bits (max 8 fits in 4 bits)
    always_comb begin
        w_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_count = w_count + {3'b000, neighbors[i]};
        end
    end

    assign next_alive = life_rule(r_alive, w_count);
    assign alive      = r_alive;

    // Cell state: load overrides advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alive <= 1'b0;
        end else if (load) begin
            r_alive <= seed;
        end else if (enable) begin
            r_alive <= next_alive;
        end
    end

endmodule
`default_nettype wire

// File: rtl/life_grid.sv
`default_nettype none
// ============================================================================
// Module      : life_grid
// Description : ROWS x COLS Game-of-Life array with IDLE/RUN/HALT control,
//               saturating generation counter and extinct/stable flags.
// Revision    : 1.0 - initial release
// ============================================================================
module life_grid
    import life_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int WRAP  = 0,
    parameter int GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seeds,
    input  logic                 run,
    input  logic                 step,
    output logic [ROWS*COLS-1:0] cells,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 extinct,
    output logic                 stable,
    output logic                 halted
);

    localparam int c_n = ROWS * COLS;

    logic [c_n-1:0]   w_next;
    logic [c_n*8-1:0] w_nbr;
    logic             w_advance;
    logic             w_all_dead;
    logic             w_no_change;
    state_t           r_state;
    state_t           w_state_next;
    logic [GEN_W-1:0] r_gen_count;
    logic             r_stable;

    // Neighbour k ordering: NW, N, NE, W, E, SW, S, SE.
    // Border handling is fixed at elaboration: wrap indices or tie to dead.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            for (genvar k = 0; k < 8; k++) begin : g_nbr
                localparam int c_dr     = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
                localparam int c_dc     = (k == 0 || k == 3 || k == 5) ? -1 :
                                          ((k == 1 || k == 6) ? 0 : 1);
                localparam int c_nr     = r + c_dr;
                localparam int c_nc     = c + c_dc;
                localparam int c_inside = (c_nr >= 0 && c_nr < ROWS &&
                                           c_nc >= 0 && c_nc < COLS) ? 1 : 0;
                localparam int c_wr     = (c_nr + ROWS) % ROWS;
                localparam int c_wc     = (c_nc + COLS) % COLS;
                if (WRAP != 0 || c_inside != 0) begin : g_live
                    assign w_nbr[(r*COLS+c)*8+k] = cells[c_wr*COLS+c_wc];
                end else begin : g_dead
                    assign w_nbr[(r*COLS+c)*8+k] = 1'b0;
                end
            end

            life_cell u_cell (
                .clk        (clk),
                .rst        (rst),
                .load       (load),
                .seed       (seeds[r*COLS+c]),
                .enable     (w_advance),
                .neighbors  (w_nbr[(r*COLS+c)*8 +: 8]),
                .next_alive (w_next[r*COLS+c]),
                .alive      (cells[r*COLS+c])
            );
        end
    end

    assign w_all_dead  = (cells == '0);
    assign w_no_change = (w_next == cells);

    // Next-state and advance decision; load wins in every state
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        if (load) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (step) begin
                        w_advance = 1'b1;
                    end else if (run) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        w_state_next = ST_IDLE;
                    end else if (w_all_dead) begin
                        w_state_next = ST_HALT;
                    end else begin
                        // Still advance on a still-life so its generation is counted
                        w_advance = 1'b1;
                        if (w_no_change) begin
                            w_state_next = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    w_state_next = ST_HALT;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Generation counter (saturating) and stability flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gen_count <= '0;
            r_stable    <= 1'b0;
        end else if (load) begin
            r_gen_count <= '0;
            r_stable    <= 1'b0;
        end else if (w_advance) begin
            if (r_gen_count != {GEN_W{1'b1}}) begin
                r_gen_count <= r_gen_count + GEN_W'(1);
            end
            r_stable <= w_no_change;
        end
    end

    assign gen_count = r_gen_count;
    assign stable    = r_stable;
    assign extinct   = w_all_dead;
    assign halted    = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_life_grid.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_grid
// Description : Directed self-checking bench for life_grid. Three instances
//               share stimulus: 8x8 bounded, 8x8 toroidal, 8x8 with 2-bit
//               generation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_grid;

    logic        clk;
    logic        rst;
    logic        load;
    logic [63:0] seeds;
    logic        run;
    logic        step;

    logic [63:0] c0, c1, c2;
    logic [15:0] g0, g1;
    logic [1:0]  g2;
    logic        e0, e1, e2;
    logic        s0, s1, s2;
    logic        h0, h1, h2;

    int errors;
    int checks;

    life_grid #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(16)) dut0 (
        .clk(clk), .rst(rst), .load(load), .seeds(seeds), .run(run), .step(step),
        .cells(c0), .gen_count(g0), .extinct(e0), .stable(s0), .halted(h0)
    );

    life_grid #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16)) dut1 (
        .clk(clk), .rst(rst), .load(load), .seeds(seeds), .run(run), .step(step),
        .cells(c1), .gen_count(g1), .extinct(e1), .stable(s1), .halted(h1)
    );

    life_grid #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(2)) dut2 (
        .clk(clk), .rst(rst), .load(load), .seeds(seeds), .run(run), .step(step),
        .cells(c2), .gen_count(g2), .extinct(e2), .stable(s2), .halted(h2)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] cb(input int r, input int c);
        logic [63:0] one;
        one = 64'd1;
        return one << (r * 8 + c);
    endfunction

    function automatic logic [63:0] blinker_h();
        return cb(3, 2) | cb(3, 3) | cb(3, 4);
    endfunction

    function automatic logic [63:0] blinker_v();
        return cb(2, 3) | cb(3, 3) | cb(4, 3);
    endfunction

    function automatic logic [63:0] block_at(input int r, input int c);
        return cb(r, c) | cb(r, c + 1) | cb(r + 1, c) | cb(r + 1, c + 1);
    endfunction

    function automatic logic [63:0] glider();
        return cb(0, 1) | cb(1, 2) | cb(2, 0) | cb(2, 1) | cb(2, 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] s);
        load  = 1'b1;
        seeds = s;
        tick();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (c0 !== 64'd0) begin errors++; $display("FAIL reset_cells: got %h expected %h", c0, 64'd0); end
        checks++; if (g0 !== 16'd0) begin errors++; $display("FAIL reset_gen: got %0d expected 0", g0); end
        checks++; if (s0 !== 1'b0) begin errors++; $display("FAIL reset_stable: got %b expected 0", s0); end
        checks++; if (h0 !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", h0); end
        checks++; if (e0 !== 1'b1) begin errors++; $display("FAIL reset_extinct: got %b expected 1", e0); end
        // Inputs are ignored while reset is held
        load  = 1'b1;
        seeds = blinker_h();
        run   = 1'b1;
        tick();
        load  = 1'b0;
        checks++; if (c0 !== 64'd0) begin errors++; $display("FAIL reset_ignores_load: got %h expected %h", c0, 64'd0); end
        rst = 1'b1;
        tick();
        tick();
        checks++; if (h0 !== 1'b1) begin errors++; $display("FAIL empty_run_halts: got %b expected 1", h0); end
        checks++; if (g0 !== 16'd0) begin errors++; $display("FAIL empty_run_gen: got %0d expected 0", g0); end
        run = 1'b0;
        do_load(64'd0);
        checks++; if (h0 !== 1'b0) begin errors++; $display("FAIL load_leaves_halt: got %b expected 0", h0); end
    endtask

    task automatic test_blinker();
        do_load(blinker_h());
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++; if (c0 !== blinker_v()) begin errors++; $display("FAIL blinker_step1: got %h expected %h", c0, blinker_v()); end
        checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL blinker_extinct: got %b expected 0", e0); end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++; if (c0 !== blinker_h()) begin errors++; $display("FAIL blinker_step2: got %h expected %h", c0, blinker_h()); end
        checks++; if (g0 !== 16'd2) begin errors++; $display("FAIL blinker_gen: got %0d expected 2", g0); end
        checks++; if (s0 !== 1'b0) begin errors++; $display("FAIL blinker_stable: got %b expected 0", s0); end
        tick();
        checks++; if (g0 !== 16'd2) begin errors++; $display("FAIL blinker_idle_hold: got %0d expected 2", g0); end
    endtask

    task automatic test_step_priority();
        do_load(blinker_h());
        step = 1'b1;
        run  = 1'b1;
        tick();
        step = 1'b0;
        checks++; if (g0 !== 16'd1) begin errors++; $display("FAIL prio_step_gen: got %0d expected 1", g0); end
        checks++; if (c0 !== blinker_v()) begin errors++; $display("FAIL prio_step_cells: got %h expected %h", c0, blinker_v()); end
        tick();
        checks++; if (g0 !== 16'd1) begin errors++; $display("FAIL run_entry_no_advance: got %0d expected 1", g0); end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++; if (g0 !== 16'd2) begin errors++; $display("FAIL run_advance: got %0d expected 2", g0); end
        run = 1'b0;
        tick();
        checks++; if (g0 !== 16'd2) begin errors++; $display("FAIL run_exit_no_advance: got %0d expected 2", g0); end
        tick();
        checks++; if (g0 !== 16'd2) begin errors++; $display("FAIL idle_after_run: got %0d expected 2", g0); end
    endtask

    task automatic test_block();
        do_load(block_at(1, 1));
        run = 1'b1;
        tick();
        tick();
        checks++; if (h0 !== 1'b1) begin errors++; $display("FAIL block_halted: got %b expected 1", h0); end
        checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL block_stable: got %b expected 1", s0); end
        checks++; if (g0 !== 16'd1) begin errors++; $display("FAIL block_gen: got %0d expected 1", g0); end
        checks++; if (c0 !== block_at(1, 1)) begin errors++; $display("FAIL block_cells: got %h expected %h", c0, block_at(1, 1)); end
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        run  = 1'b0;
        tick();
        checks++; if (g0 !== 16'd1) begin errors++; $display("FAIL halt_ignores_inputs: got %0d expected 1", g0); end
        checks++; if (h0 !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", h0); end
        do_load(block_at(1, 1));
        checks++; if (s0 !== 1'b0) begin errors++; $display("FAIL load_clears_stable: got %b expected 0", s0); end
    endtask

    task automatic test_extinction();
        do_load(cb(4, 4));
        run = 1'b1;
        tick();
        tick();
        checks++; if (c0 !== 64'd0) begin errors++; $display("FAIL extinct_cells: got %h expected %h", c0, 64'd0); end
        checks++; if (e0 !== 1'b1) begin errors++; $display("FAIL extinct_flag: got %b expected 1", e0); end
        checks++; if (h0 !== 1'b0) begin errors++; $display("FAIL extinct_not_yet_halted: got %b expected 0", h0); end
        tick();
        checks++; if (h0 !== 1'b1) begin errors++; $display("FAIL extinct_halted: got %b expected 1", h0); end
        checks++; if (g0 !== 16'd1) begin errors++; $display("FAIL extinct_gen: got %0d expected 1", g0); end
        run = 1'b0;
        do_load(64'd0);
    endtask

    task automatic test_load_mid_run();
        do_load(blinker_h());
        run = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (g0 !== 16'd2) begin errors++; $display("FAIL midrun_pre_gen: got %0d expected 2", g0); end
        load  = 1'b1;
        seeds = block_at(4, 4);
        tick();
        load  = 1'b0;
        checks++; if (c0 !== block_at(4, 4)) begin errors++; $display("FAIL midrun_load_cells: got %h expected %h", c0, block_at(4, 4)); end
        checks++; if (g0 !== 16'd0) begin errors++; $display("FAIL midrun_load_gen: got %0d expected 0", g0); end
        tick();
        checks++; if (g0 !== 16'd0) begin errors++; $display("FAIL midrun_load_idle: got %0d expected 0", g0); end
        checks++; if (h0 !== 1'b0) begin errors++; $display("FAIL midrun_load_halted: got %b expected 0", h0); end
        run = 1'b0;
        tick();
    endtask

    task automatic test_glider();
        do_load(glider());
        step = 1'b1;
        repeat (32) tick();
        step = 1'b0;
        checks++; if (c1 !== glider()) begin errors++; $display("FAIL glider_wrap_cells: got %h expected %h", c1, glider()); end
        checks++; if (g1 !== 16'd32) begin errors++; $display("FAIL glider_wrap_gen: got %0d expected 32", g1); end
        checks++; if (c0 !== block_at(6, 6)) begin errors++; $display("FAIL glider_border_cells: got %h expected %h", c0, block_at(6, 6)); end
        run = 1'b1;
        tick();
        tick();
        checks++; if (h0 !== 1'b1) begin errors++; $display("FAIL glider_border_halted: got %b expected 1", h0); end
        checks++; if (h1 !== 1'b0) begin errors++; $display("FAIL glider_wrap_running: got %b expected 0", h1); end
        run = 1'b0;
        do_load(64'd0);
    endtask

    task automatic test_saturation_and_reset();
        do_load(blinker_h());
        run = 1'b1;
        tick();
        repeat (6) tick();
        checks++; if (g2 !== 2'd3) begin errors++; $display("FAIL sat_gen: got %0d expected 3", g2); end
        checks++; if (g0 !== 16'd6) begin errors++; $display("FAIL sat_wide_gen: got %0d expected 6", g0); end
        checks++; if (c2 !== blinker_h()) begin errors++; $display("FAIL sat_cells: got %h expected %h", c2, blinker_h()); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (c2 !== 64'd0) begin errors++; $display("FAIL async_rst_cells: got %h expected %h", c2, 64'd0); end
        checks++; if (g2 !== 2'd0) begin errors++; $display("FAIL async_rst_gen: got %0d expected 0", g2); end
        checks++; if (s2 !== 1'b0) begin errors++; $display("FAIL async_rst_stable: got %b expected 0", s2); end
        checks++; if (h2 !== 1'b0) begin errors++; $display("FAIL async_rst_halted: got %b expected 0", h2); end
        checks++; if (e2 !== 1'b1) begin errors++; $display("FAIL async_rst_extinct: got %b expected 1", e2); end
        run = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (g0 !== 16'd0) begin errors++; $display("FAIL post_rst_gen: got %0d expected 0", g0); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clk    = 1'b0;
        rst    = 1'b0;
        load   = 1'b0;
        seeds  = 64'd0;
        run    = 1'b0;
        step   = 1'b0;

        test_reset();
        test_blinker();
        test_step_priority();
        test_block();
        test_extinction();
        test_load_mid_run();
        test_glider();
        test_saturation_and_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
